// File: rtl/piezo_seq.sv
// Piezo buzzer sequencer: continuous warning tone, or an N-beep arrival pattern, on a complementary drive pair.
// Latency: an input sampled at one edge shows on buzz/buzz_n/busy right after that edge; warn and arrive_req are never stalled.
module piezo_seq #(
    parameter int TONE_DIV  = 12500,
    parameter int BEEP_ON   = 5000000,
    parameter int BEEP_OFF  = 5000000,
    parameter int NUM_BEEPS = 3,
    parameter int CNT_W     = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic warn,
    input  logic arrive_req,
    output logic buzz,
    output logic buzz_n,
    output logic busy
);

    localparam int TONE_W = $clog2(TONE_DIV);
    localparam int BEEP_W = $clog2(NUM_BEEPS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WARN = 2'd1,
        BEEP = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    phase_cnt;
    logic [BEEP_W-1:0]   beep_cnt;
    logic [TONE_W-1:0]   tone_cnt;
    logic [1:0]          rst_sync;
    logic                rst_int_n;
    logic                sounding_nxt;
    logic                state_chg;

    // Reset asserts immediately but releases only on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (warn)            state_nxt = WARN;
                else if (arrive_req) state_nxt = BEEP;
            end
            WARN: if (!warn) state_nxt = IDLE;
            BEEP: begin
                if (warn) state_nxt = WARN;
                else if (phase_cnt == CNT_W'(BEEP_ON - 1))
                    state_nxt = (beep_cnt < BEEP_W'(NUM_BEEPS - 1)) ? GAP : IDLE;
            end
            GAP: begin
                if (warn)                                    state_nxt = WARN;
                else if (phase_cnt == CNT_W'(BEEP_OFF - 1)) state_nxt = BEEP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sounding_nxt = (state_nxt == WARN) || (state_nxt == BEEP);
    assign state_chg    = (state_nxt != state);

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state     <= IDLE;
            phase_cnt <= '0;
            beep_cnt  <= '0;
            tone_cnt  <= '0;
            buzz      <= 1'b0;
            buzz_n    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);

            // Only BEEP and GAP are timed; other states park the counter at 0.
            if (state_chg || state == IDLE || state == WARN)
                phase_cnt <= '0;
            else
                phase_cnt <= phase_cnt + 1'b1;

            if (state == IDLE && state_nxt == BEEP)
                beep_cnt <= '0;
            else if (state == BEEP && state_nxt == GAP)
                beep_cnt <= beep_cnt + 1'b1;

            // Every sounding episode starts high so each beep begins in the same phase.
            if (!sounding_nxt) begin
                buzz     <= 1'b0;
                buzz_n   <= 1'b0;
                tone_cnt <= '0;
            end else if (state_chg) begin
                buzz     <= 1'b1;
                buzz_n   <= 1'b0;
                tone_cnt <= '0;
            end else if (tone_cnt == TONE_W'(TONE_DIV - 1)) begin
                buzz     <= ~buzz;
                buzz_n   <= buzz;
                tone_cnt <= '0;
            end else begin
                tone_cnt <= tone_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_piezo_seq.sv
// Directed bench for piezo_seq with short timing parameters.
module tb_piezo_seq;

    localparam int TD  = 4;
    localparam int BON = 20;
    localparam int BOF = 10;
    localparam int NB  = 3;
    localparam int PATTERN = NB * BON + (NB - 1) * BOF;

    logic clk = 1'b0;
    logic rst_n;
    logic warn;
    logic arrive_req;
    logic buzz;
    logic buzz_n;
    logic busy;

    int errors = 0;
    int checks = 0;

    piezo_seq #(
        .TONE_DIV (TD),
        .BEEP_ON  (BON),
        .BEEP_OFF (BOF),
        .NUM_BEEPS(NB),
        .CNT_W    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .warn      (warn),
        .arrive_req(arrive_req),
        .buzz      (buzz),
        .buzz_n    (buzz_n),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected buzz at offset i from the start of an undisturbed arrival pattern.
    function automatic logic pat_buzz(input int i);
        int t;
        t = i % (BON + BOF);
        if (t >= BON) return 1'b0;
        return ((t / TD) % 2) == 0;
    endfunction

    initial begin
        int bursts;
        int busy_cyc;
        logic prev_silent;

        rst_n      = 1'b0;
        warn       = 1'b0;
        arrive_req = 1'b0;

        // 1: reset, then idle with no stimulus
        repeat (5) tick();
        chk("rst_outputs", {29'd0, buzz, buzz_n, busy}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("idle_silent", {29'd0, buzz, buzz_n, busy}, 32'd0);
        end

        // 2: continuous warning tone
        warn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("warn_buzz", {31'd0, buzz}, {31'd0, ((i / TD) % 2) == 0});
            chk("warn_buzz_n", {31'd0, buzz_n}, {31'd0, ~buzz});
            chk("warn_busy", {31'd0, busy}, 32'd1);
        end
        warn = 1'b0;
        tick();
        chk("warn_release", {29'd0, buzz, buzz_n, busy}, 32'd0);

        // 3: full arrival pattern
        arrive_req = 1'b1;
        tick();
        arrive_req = 1'b0;
        for (int i = 0; i < PATTERN; i++) begin
            chk("pat_buzz", {31'd0, buzz}, {31'd0, pat_buzz(i)});
            chk("pat_buzz_n", {31'd0, buzz_n}, {31'd0, pat_buzz(i) ? 1'b0 : ((i % (BON + BOF)) < BON)});
            chk("pat_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        chk("pat_end", {29'd0, buzz, buzz_n, busy}, 32'd0);
        tick();

        // 4: warning raised 5 cycles into the second gap
        arrive_req = 1'b1;
        tick();
        arrive_req = 1'b0;
        repeat (2 * BON + BOF + 5) tick();
        chk("gap2_silent", {29'd0, buzz, buzz_n, busy}, 32'b001);
        warn = 1'b1;
        tick();
        chk("gap_to_warn", {29'd0, buzz, buzz_n, busy}, 32'b101);
        repeat (5) tick();
        chk("gap_warn_tone", {29'd0, buzz, buzz_n, busy}, 32'b011);
        warn = 1'b0;
        tick();
        busy_cyc = 0;
        for (int i = 0; i < 60; i++) begin
            if (busy || buzz || buzz_n) busy_cyc++;
            tick();
        end
        chk("no_resume", busy_cyc, 32'd0);

        // 5a: warn and arrive_req together in IDLE
        warn       = 1'b1;
        arrive_req = 1'b1;
        tick();
        arrive_req = 1'b0;
        chk("warn_prio", {29'd0, buzz, buzz_n, busy}, 32'b101);
        repeat (3) tick();
        warn = 1'b0;
        tick();
        busy_cyc = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy || buzz) busy_cyc++;
            tick();
        end
        chk("dropped_arrive", busy_cyc, 32'd0);

        // 5b: extra arrive_req pulses mid-pattern do not restart it
        bursts      = 0;
        busy_cyc    = 0;
        prev_silent = 1'b1;
        arrive_req  = 1'b1;
        tick();
        arrive_req = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if (buzz && prev_silent) bursts++;
            if (busy) busy_cyc++;
            prev_silent = !buzz && !buzz_n;
            arrive_req  = (i == 25) || (i == 40);
            tick();
        end
        arrive_req = 1'b0;
        chk("burst_count", bursts, NB);
        chk("busy_cycles", busy_cyc, PATTERN);

        // 6: asynchronous reset mid-beep
        arrive_req = 1'b1;
        tick();
        arrive_req = 1'b0;
        repeat (5) tick();
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {29'd0, buzz, buzz_n, busy}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        busy_cyc = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (busy || buzz || buzz_n) busy_cyc++;
        end
        chk("post_rst_silent", busy_cyc, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
